// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the memory-access stage.
package mem_lsu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_DATA_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LBU  = 4'd2;
  localparam logic [3:0] MEMOP_LH   = 4'd3;
  localparam logic [3:0] MEMOP_LHU  = 4'd4;
  localparam logic [3:0] MEMOP_LW   = 4'd5;
  localparam logic [3:0] MEMOP_SB   = 4'd6;
  localparam logic [3:0] MEMOP_SH   = 4'd7;
  localparam logic [3:0] MEMOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEMOP_LB) && (op <= MEMOP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEMOP_SB) && (op <= MEMOP_SW);
  endfunction

  // Halfword needs an even address, word needs a word-aligned address.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return off[0];
      MEMOP_LW, MEMOP_SW:            return off != 2'b00;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Big-endian byte-lane steering: byte enables, store replication, load extension.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  memop,
  input  logic [1:0]  offset,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel_c,
  output logic [31:0] wdata_c,
  output logic [31:0] ldata_c
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Offset 0 is the most significant byte on this big-endian bus.
  assign lane_byte = rdata[{~offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? rdata[15:0] : rdata[31:16];

  // Lane selection and data formatting per access size.
  always_comb begin
    sel_c   = 4'b0000;
    wdata_c = sdata;
    ldata_c = rdata;
    case (memop)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
        sel_c   = 4'b1000 >> offset;
        wdata_c = {4{sdata[7:0]}};
        ldata_c = (memop == MEMOP_LB) ? {{24{lane_byte[7]}}, lane_byte}
                                      : {24'h000000, lane_byte};
      end
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
        sel_c   = offset[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{sdata[15:0]}};
        ldata_c = (memop == MEMOP_LH) ? {{16{lane_half[15]}}, lane_half}
                                      : {16'h0000, lane_half};
      end
      MEMOP_LW, MEMOP_SW: begin
        sel_c = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MIPS memory-access stage: pass-through for ALU ops, handshaked bus access for loads/stores.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_we,
  input  logic [4:0]    ex_waddr,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_hi,
  input  logic [DW-1:0] ex_lo,
  input  logic          ex_whilo,
  input  logic [3:0]    ex_memop,
  input  logic [AW-1:0] ex_maddr,
  input  logic [DW-1:0] ex_sdata,
  output logic          mem_we,
  output logic [4:0]    mem_waddr,
  output logic [DW-1:0] mem_result,
  output logic [DW-1:0] mem_hi,
  output logic [DW-1:0] mem_lo,
  output logic          mem_whilo,
  output logic          mem_excp_align,
  output logic          stall_req,
  output logic          dbus_req,
  output logic          dbus_we,
  output logic [3:0]    dbus_sel,
  output logic [AW-1:0] dbus_addr,
  output logic [DW-1:0] dbus_wdata,
  input  logic          dbus_gnt,
  input  logic          dbus_rvalid,
  input  logic [DW-1:0] dbus_rdata
);

  state_e        state, state_nxt;
  logic [DW-1:0] rdata_q;
  logic [3:0]    lane_sel;
  logic [DW-1:0] lane_wdata;
  logic [DW-1:0] lane_ldata;
  logic          op_load, op_store, op_misal;

  assign op_load  = is_load(ex_memop);
  assign op_store = is_store(ex_memop);
  assign op_misal = is_misaligned(ex_memop, ex_maddr[1:0]);

  mem_lsu_lane u_lane (
    .memop   (ex_memop),
    .offset  (ex_maddr[1:0]),
    .sdata   (ex_sdata),
    .rdata   (rdata_q),
    .sel_c   (lane_sel),
    .wdata_c (lane_wdata),
    .ldata_c (lane_ldata)
  );

  // Access state and captured read data; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rdata_q <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT_R && dbus_rvalid) begin
        rdata_q <= dbus_rdata;
      end
    end
  end

  // Next state and stage outputs; everything is held at zero while in reset.
  always_comb begin
    state_nxt      = state;
    mem_we         = DISABLE;
    mem_waddr      = '0;
    mem_result     = ZERO_WORD;
    mem_hi         = ZERO_WORD;
    mem_lo         = ZERO_WORD;
    mem_whilo      = DISABLE;
    mem_excp_align = DISABLE;
    stall_req      = DISABLE;
    dbus_req       = DISABLE;
    dbus_we        = DISABLE;
    dbus_sel       = 4'b0000;
    dbus_addr      = '0;
    dbus_wdata     = ZERO_WORD;
    if (!rst) begin
      mem_waddr  = ex_waddr;
      mem_hi     = ex_hi;
      mem_lo     = ex_lo;
      mem_result = ex_result;
      dbus_we    = op_store;
      dbus_sel   = lane_sel;
      dbus_addr  = {ex_maddr[AW-1:2], 2'b00};
      dbus_wdata = lane_wdata;
      case (state)
        ST_IDLE, ST_REQ: begin
          if (!(op_load || op_store)) begin
            mem_we    = ex_we;
            mem_whilo = ex_whilo;
            state_nxt = ST_IDLE;
          end else if (op_misal) begin
            mem_excp_align = ENABLE;
            state_nxt      = ST_IDLE;
          end else begin
            dbus_req  = ENABLE;
            stall_req = ENABLE;
            if (dbus_gnt) begin
              state_nxt = op_store ? ST_DONE : ST_WAIT_R;
            end else begin
              state_nxt = ST_REQ;
            end
          end
        end
        ST_WAIT_R: begin
          stall_req = ENABLE;
          if (dbus_rvalid) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          mem_we    = ex_we;
          mem_whilo = ex_whilo;
          if (op_load) begin
            mem_result = lane_ldata;
          end
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
